aes_key_sched_buf: RTL and testbench
====================================

AES_KEY_SCHED_BUF -- requirements
Module: aes_key_sched_buf

Interface
REQ-001 Parameter KEY_BITS, default 128, meaning cipher key length; SHALL accept 128 or 256 only, giving NK=KEY_BITS/32 and NR=10 or 14.
REQ-002 clk  input  1  sole clock; all state changes SHALL occur on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 key_in  input  256  cipher key, MSB-aligned; only key_in[255:256-KEY_BITS] SHALL be used.
REQ-005 key_valid  input  1  key_in and dir are valid.
REQ-006 key_ready  output  1  block accepts a new key.
REQ-007 dir  input  1  stream order: 0 = rk0..rkNR (encrypt), 1 = rkNR..rk0 (decrypt).
REQ-008 replay  input  1  restream stored round keys in order dir without re-expansion.
REQ-009 rk_data  output  128  current round key.
REQ-010 rk_idx  output  4  round index of rk_data.
REQ-011 rk_valid  output  1  rk_data, rk_idx and rk_last are valid.
REQ-012 rk_ready  input  1  consumer accepts the round key.
REQ-013 rk_last  output  1  current round key is the final key of the stream.
REQ-014 busy  output  1  state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, EXPAND and STREAM.
REQ-016 key_ready SHALL be 1 only in IDLE.
REQ-017 Key accept: key_valid=1 in IDLE at edge T SHALL latch key_in and dir, clear the stored flag and enter EXPAND.
REQ-018 EXPAND SHALL write one 128-bit round key per cycle into an internal (NR+1)-entry store: rk0 at T+1 through rkNR at T+NR+1.
REQ-019 Expansion SHALL follow FIPS-197 with words w[j] = w[j-NK] ^ temp.
  - temp = SubWord(RotWord(w[j-1])) ^ Rcon[j/NK] when j mod NK = 0.
  - temp = SubWord(w[j-1]) when NK=8 and j mod 8 = 4.
  - temp = w[j-1] otherwise.
REQ-020 Rcon SHALL be the byte sequence 01,02,04,08,10,20,40,80,1b,36 placed in the MS byte of the word.
REQ-021 When rkNR is written, the block SHALL set the stored flag and enter STREAM at T+NR+2.
REQ-022 STREAM SHALL hold rk_valid=1, with rk_idx = current pointer and rk_data = store[rk_idx].
REQ-023 The pointer SHALL start at 0 for dir=0 or NR for dir=1.
REQ-024 A transfer occurs on an edge with rk_valid=1 and rk_ready=1; the pointer SHALL then step by +1 (dir=0) or -1 (dir=1).
REQ-025 With rk_ready=0, rk_data, rk_idx and rk_last SHALL hold stable.
REQ-026 rk_last SHALL be 1 exactly when rk_idx = NR (dir=0) or 0 (dir=1).
REQ-027 The transfer with rk_last=1 SHALL return the FSM to IDLE; key_ready SHALL be 1 the next cycle, with no pointer wrap-around.
REQ-028 Replay: replay=1 in IDLE with key_valid=0 and the stored flag set SHALL latch dir and enter STREAM directly (rk_valid=1 the next cycle).
REQ-029 replay with the stored flag clear SHALL be ignored.
REQ-030 key_valid and replay both high in IDLE: key_valid SHALL win.
REQ-031 key_valid and replay SHALL be ignored outside IDLE.
REQ-032 rk_data and rk_idx SHALL be 0 whenever rk_valid=0.
REQ-033 Throughput SHALL be one round key per cycle while rk_ready=1.

Reset
REQ-034 rst=1 SHALL force IDLE and clear the stored flag and pointer.
REQ-035 Next cycle after rst=1: key_ready=1, rk_valid=0, rk_last=0, busy=0, rk_data=0, rk_idx=0.
REQ-036 rst=1 mid-EXPAND or mid-STREAM SHALL abort the stream without emitting further keys, and a subsequent replay SHALL be ignored until a new key is expanded.
REQ-037 Store contents need not be cleared by reset.

Verification
REQ-038 KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, dir=0, rk_ready=1 -> rk_valid first at T+12; rk1 = d6aa74fdd2af72fadaa678f1d6ab76fe; rk10 = 13111d7fe3944a17f307a78b4d2b30c5 with rk_last=1.
REQ-039 KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, dir=1 -> first output rk_idx=10, rk_data=d014f9a8c9ee2589e13f0cc8b6630ca6; last output rk_idx=0 equals the key.
REQ-040 KEY_BITS=256, key 000102...1e1f, dir=1 -> rk_valid first at T+16; first output rk_idx=14, rk_data=24fc79ccbf0979e9371ac23c6d68de36; 15 transfers total.
REQ-041 Random rk_ready backpressure (including 5-cycle stall on rk_last) -> outputs stable while stalled; sequence identical to the no-stall run.
REQ-042 After a dir=0 stream, replay=1 with dir=1 -> rkNR..rk0 with no EXPAND cycles; rst=1 at third STREAM cycle then replay=1 -> ignored, key_ready=1, rk_valid=0.

Source files
------------

// File: rtl/aes_key_sched_buf.sv
// AES key schedule buffer: expands a 128/256-bit key into NR+1 round keys and streams them in either order.
// Latency: first round key valid NR+2 cycles after key accept; replay streams the next cycle; one key per cycle.
// Backpressure: rk_ready=0 holds rk_data/rk_idx/rk_last; key_ready is high only while idle.
module aes_key_sched_buf #(
    parameter int KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic         dir,
    input  logic         replay,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         rk_last,
    output logic         busy
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = (KEY_BITS == 256) ? 14 : 10;
    localparam logic [3:0] NR4 = 4'(NR);
    localparam logic [3:0] KW4 = 4'(NK / 4);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] pos;
        pos = {3'b000, ~b} << 3;
        return SBOX[pos +: 8];
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rotword(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic is_last(input logic [3:0] p, input logic d);
        return d ? (p == 4'd0) : (p == NR4);
    endfunction

    state_t       state;
    logic [31:0]  win [0:7];
    logic [3:0]   cnt;
    logic [3:0]   ptr;
    logic         dir_q;
    logic         stored;
    logic [127:0] store [0:NR];

    logic [31:0]  temp_w;
    logic [31:0]  nw [0:3];
    logic [127:0] wr_rk;
    logic         rot_step;
    logic [3:0]   rc_idx;
    logic [3:0]   ptr_nx;
    logic [3:0]   ptr_start;

    assign key_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign ptr_nx    = dir_q ? (ptr - 4'd1) : (ptr + 4'd1);
    assign ptr_start = dir ? NR4 : 4'd0;

    // win holds the last NK schedule words; round key cnt is words 4*cnt..4*cnt+3.
    always_comb begin
        rot_step = (NK == 4) || !cnt[0];
        rc_idx   = (NK == 4) ? cnt : (cnt >> 1);
        temp_w   = rot_step ? (subword(rotword(win[NK-1])) ^ {rcon(rc_idx), 24'h000000})
                            : subword(win[NK-1]);
        nw[0] = win[0] ^ temp_w;
        nw[1] = win[1] ^ nw[0];
        nw[2] = win[2] ^ nw[1];
        nw[3] = win[3] ^ nw[2];
        if (cnt == 4'd0) begin
            wr_rk = {win[0], win[1], win[2], win[3]};
        end else if (cnt < KW4) begin
            wr_rk = {win[4], win[5], win[6], win[7]};
        end else begin
            wr_rk = {nw[0], nw[1], nw[2], nw[3]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == EXPAND && cnt <= NR4) begin
            store[cnt] <= wr_rk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            stored   <= 1'b0;
            ptr      <= 4'd0;
            cnt      <= 4'd0;
            dir_q    <= 1'b0;
            rk_valid <= 1'b0;
            rk_data  <= 128'd0;
            rk_idx   <= 4'd0;
            rk_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        for (int k = 0; k < 8; k++) begin
                            win[k] <= key_in[255-32*k -: 32];
                        end
                        dir_q  <= dir;
                        stored <= 1'b0;
                        cnt    <= 4'd0;
                        ptr    <= ptr_start;
                        state  <= EXPAND;
                    end else if (replay && stored) begin
                        dir_q    <= dir;
                        ptr      <= ptr_start;
                        rk_data  <= store[ptr_start];
                        rk_idx   <= ptr_start;
                        rk_last  <= is_last(ptr_start, dir);
                        rk_valid <= 1'b1;
                        state    <= STREAM;
                    end
                end
                EXPAND: begin
                    if (cnt <= NR4) begin
                        if (cnt >= KW4) begin
                            for (int k = 0; k < NK - 4; k++) begin
                                win[k] <= win[k+4];
                            end
                            for (int k = 0; k < 4; k++) begin
                                win[NK-4+k] <= nw[k];
                            end
                        end
                        if (cnt == NR4) begin
                            stored <= 1'b1;
                        end
                        cnt <= cnt + 4'd1;
                    end else begin
                        // Spare cycle lets the final store write land before the first read.
                        rk_data  <= store[ptr];
                        rk_idx   <= ptr;
                        rk_last  <= is_last(ptr, dir_q);
                        rk_valid <= 1'b1;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (rk_ready) begin
                        if (rk_last) begin
                            rk_valid <= 1'b0;
                            rk_data  <= 128'd0;
                            rk_idx   <= 4'd0;
                            rk_last  <= 1'b0;
                            ptr      <= 4'd0;
                            state    <= IDLE;
                        end else begin
                            ptr      <= ptr_nx;
                            rk_data  <= store[ptr_nx];
                            rk_idx   <= ptr_nx;
                            rk_last  <= is_last(ptr_nx, dir_q);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_sched_buf.sv
// Bench for aes_key_sched_buf: 128-bit and 256-bit instances driven with known-answer keys.
// Expected round keys are queued at issue time; a monitor pops and compares on every transfer.
// Ready is either held high or randomly dropped with a forced stall on the final key.
module tb_aes_key_sched_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [255:0] a_key, b_key;
    logic         a_kv, b_kv, a_dir, b_dir, a_rep, b_rep, a_rdy, b_rdy;
    logic         a_kr, b_kr, a_vld, b_vld, a_last, b_last, a_busy, b_busy;
    logic [127:0] a_dat, b_dat;
    logic [3:0]   a_idx, b_idx;

    aes_key_sched_buf #(.KEY_BITS(128)) u128 (
        .clk(clk), .rst(rst), .key_in(a_key), .key_valid(a_kv), .key_ready(a_kr),
        .dir(a_dir), .replay(a_rep), .rk_data(a_dat), .rk_idx(a_idx), .rk_valid(a_vld),
        .rk_ready(a_rdy), .rk_last(a_last), .busy(a_busy)
    );

    aes_key_sched_buf #(.KEY_BITS(256)) u256 (
        .clk(clk), .rst(rst), .key_in(b_key), .key_valid(b_kv), .key_ready(b_kr),
        .dir(b_dir), .replay(b_rep), .rk_data(b_dat), .rk_idx(b_idx), .rk_valid(b_vld),
        .rk_ready(b_rdy), .rk_last(b_last), .busy(b_busy)
    );

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] data;
        logic         last;
        bit           cd;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int n_vec = 0;
    int n_err = 0;
    int rmode = 0;
    int stall = 0;
    bit mon_en = 1'b0;
    bit done = 1'b0;
    logic [127:0] rk_a [0:10];
    logic [127:0] rk_b [0:10];
    logic         pv_stall [0:1];
    logic [133:0] pv_snap [0:1];

    localparam logic [255:0] KEY_A   = {128'h000102030405060708090a0b0c0d0e0f, 128'd0};
    localparam logic [255:0] KEY_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0};
    localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon_one(input int w);
        logic v, r, l;
        logic [3:0] i;
        logic [127:0] d;
        exp_t e;
        if (w == 0) begin v = a_vld; r = a_rdy; l = a_last; i = a_idx; d = a_dat; end
        else        begin v = b_vld; r = b_rdy; l = b_last; i = b_idx; d = b_dat; end
        if (!v) begin
            chk("idle_data", 160'(d), 160'd0);
            chk("idle_idx", 160'(i), 160'd0);
        end
        if (pv_stall[w]) chk("hold", 160'({v, l, i, d}), 160'(pv_snap[w]));
        if (v && r && !rst) begin
            if ((w == 0 && qa.size() == 0) || (w == 1 && qb.size() == 0)) begin
                n_vec++;
                n_err++;
                $display("FAIL extra_xfer: dut %0d idx %0d with nothing expected", w, i);
            end else begin
                if (w == 0) e = qa.pop_front();
                else        e = qb.pop_front();
                chk("rk_idx", 160'(i), 160'(e.idx));
                chk("rk_last", 160'(l), 160'(e.last));
                if (e.cd) chk("rk_data", 160'(d), 160'(e.data));
            end
        end
        pv_stall[w] = v && !r && !rst;
        pv_snap[w]  = {v, l, i, d};
    endtask

    task automatic push128(input bit tbl_b, input logic d, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            int p;
            p = d ? 10 - k : k;
            e.idx  = 4'(p);
            e.data = tbl_b ? rk_b[p] : rk_a[p];
            e.last = (k == 10);
            e.cd   = 1'b1;
            qa.push_back(e);
        end
    endtask

    task automatic send(input int w, input logic [255:0] k, input logic d, input logic rep);
        int n = 0;
        while (!(w == 0 ? a_kr : b_kr) && n < 100) begin @(posedge clk); #1; n++; end
        chk("send_ready", 160'(n < 100), 160'd1);
        if (w == 0) begin a_key = k; a_kv = 1'b1; a_dir = d; a_rep = rep; end
        else        begin b_key = k; b_kv = 1'b1; b_dir = d; b_rep = rep; end
        @(posedge clk); #1;
        a_kv = 1'b0; a_rep = 1'b0; b_kv = 1'b0; b_rep = 1'b0;
        a_key = '1;  b_key = '1;
    endtask

    task automatic wait_lat(input int w, input int exp, input int n0);
        int n = n0;
        while (!(w == 0 ? a_vld : b_vld) && n < 60) begin @(posedge clk); #1; n++; end
        chk("latency", 160'(n), 160'(exp));
    endtask

    task automatic drain(input int w);
        int n = 0;
        while (((w == 0 ? qa.size() : qb.size()) != 0 || !(w == 0 ? a_kr : b_kr)) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", 160'(n < 300), 160'd1);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_key_ready"}, 160'(a_kr), 160'd1);
        chk({name, "_valid"}, 160'(a_vld), 160'd0);
        chk({name, "_busy"}, 160'(a_busy), 160'd0);
        chk({name, "_last"}, 160'(a_last), 160'd0);
    endtask

    initial begin
        rk_a[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk_a[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rk_a[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rk_a[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rk_a[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rk_a[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rk_a[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rk_a[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rk_a[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rk_a[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rk_a[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        rk_b[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_b[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_b[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_b[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_b[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_b[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_b[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_b[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_b[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_b[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_b[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        pv_stall[0] = 1'b0; pv_stall[1] = 1'b0;
        pv_snap[0] = '0;    pv_snap[1] = '0;
        rst = 1'b1;
        a_key = '0; a_kv = 1'b0; a_dir = 1'b0; a_rep = 1'b0;
        b_key = '0; b_kv = 1'b0; b_dir = 1'b0; b_rep = 1'b0; b_rdy = 1'b1;

        fork
            begin : stim
                repeat (2) @(posedge clk);
                #1;
                chk_idle("rst");
                chk("rst_data", 160'(a_dat), 160'd0);
                chk("rst_idx", 160'(a_idx), 160'd0);
                chk("rst256_key_ready", 160'(b_kr), 160'd1);
                chk("rst256_valid", 160'(b_vld), 160'd0);
                chk("rst256_busy", 160'(b_busy), 160'd0);
                rst = 1'b0;
                mon_en = 1'b1;

                // replay with nothing stored
                a_rep = 1'b1;
                @(posedge clk); #1;
                a_rep = 1'b0;
                chk_idle("replay_empty");

                // encrypt order, full throughput
                push128(1'b0, 1'b0, 11);
                send(0, KEY_A, 1'b0, 1'b0);
                wait_lat(0, 12, 0);
                drain(0);

                // decrypt order; key_valid/replay during EXPAND must be ignored
                push128(1'b1, 1'b1, 11);
                send(0, KEY_B, 1'b1, 1'b0);
                a_kv = 1'b1; a_key = KEY_A; a_rep = 1'b1; a_dir = 1'b0;
                @(posedge clk); #1;
                a_kv = 1'b0; a_rep = 1'b0;
                wait_lat(0, 12, 1);
                drain(0);

                // key_valid beats replay; random backpressure with stall on last
                rmode = 1;
                push128(1'b0, 1'b0, 11);
                send(0, KEY_A, 1'b0, 1'b1);
                wait_lat(0, 12, 0);
                drain(0);
                rmode = 0;
                @(posedge clk); #1;

                // replay in decrypt order straight into STREAM
                push128(1'b0, 1'b1, 11);
                a_dir = 1'b1; a_rep = 1'b1;
                @(posedge clk); #1;
                a_rep = 1'b0;
                chk("replay_valid", 160'(a_vld), 160'd1);
                chk("replay_busy", 160'(a_busy), 160'd1);
                drain(0);

                // reset during the third STREAM cycle kills the stream and the stored flag
                push128(1'b0, 1'b0, 2);
                a_dir = 1'b0; a_rep = 1'b1;
                @(posedge clk); #1;
                a_rep = 1'b0;
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk_idle("mid_rst");
                chk("mid_rst_pending", 160'(qa.size()), 160'd0);
                a_rep = 1'b1;
                @(posedge clk); #1;
                a_rep = 1'b0;
                chk_idle("replay_after_rst");
                @(posedge clk); #1;
                chk("replay_after_rst_valid2", 160'(a_vld), 160'd0);

                // 256-bit key, decrypt order
                begin
                    exp_t e;
                    for (int k = 0; k < 15; k++) begin
                        e.idx  = 4'(14 - k);
                        e.last = (k == 14);
                        e.cd   = (k == 0) || (k == 14);
                        e.data = (k == 0) ? 128'h24fc79ccbf0979e9371ac23c6d68de36
                                          : 128'h000102030405060708090a0b0c0d0e0f;
                        qb.push_back(e);
                    end
                end
                send(1, KEY_256, 1'b1, 1'b0);
                wait_lat(1, 16, 0);
                drain(1);
                repeat (3) @(posedge clk);
                done = 1'b1;
            end
            begin : mon
                while (!done) begin
                    @(negedge clk);
                    if (mon_en && !done) begin
                        mon_one(0);
                        mon_one(1);
                    end
                end
            end
            begin : rdy_drv
                a_rdy = 1'b1;
                while (!done) begin
                    @(posedge clk); #1;
                    if (rmode == 0) begin
                        a_rdy = 1'b1;
                        stall = 0;
                    end else if (a_vld && a_last && stall < 5) begin
                        a_rdy = 1'b0;
                        stall++;
                    end else begin
                        a_rdy = 1'($urandom_range(0, 1));
                        if (!a_vld) stall = 0;
                    end
                end
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
